instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter ISSUE_GAP, default 3, cycles per instruction slot; legal range is 2 to 15.
REQ-003 SHALL have parameter DRAIN_SLOTS, default 3, NOP slots issued after end of program, matching pipeline depth.
REQ-004 SHALL have one clock, clk, with all state on its rising edge; reset is asynchronous and active-low, port rst.
REQ-005 Ports, each as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins execution at address 0.
- halt_req  in  1  level; stop after the current slot.
- imem_rd_en  out  1  synchronous-read request.
- imem_addr  out  ADDR_W  read address.
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en.
- instruction  out  32  word to the CPU core, held for a full slot.
- instr_valid  out  1  high in the first cycle of each real (non-NOP) slot.
- pc  out  ADDR_W  address of the word currently on instruction.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE.

Function
REQ-006 SHALL implement the states IDLE, PRIME, RUN, DRAIN and DONE.
REQ-007 IDLE or DONE with start=1 SHALL go to PRIME, clear done, set busy, and assert imem_rd_en with imem_addr=0 in that cycle.
REQ-008 start SHALL be ignored in PRIME, RUN and DRAIN.
REQ-009 PRIME SHALL last 1 cycle, during which imem_rdata is valid; the next edge SHALL load instruction=imem_rdata and pc=0 and enter RUN with slot counter cnt=0.
REQ-010 In RUN, cnt SHALL count 0..ISSUE_GAP-1 and wrap; instr_valid=1 only when cnt=0, and instruction and pc SHALL be stable for all ISSUE_GAP cycles.
REQ-011 In RUN at cnt=ISSUE_GAP-2, the block SHALL assert imem_rd_en for one cycle with imem_addr=pc+1.
- At the cnt=ISSUE_GAP-1 edge: instruction<=imem_rdata and pc<=pc+1.
- Consecutive instr_valid pulses are therefore exactly ISSUE_GAP cycles apart.
REQ-012 A loaded word equal to HALT_WORD (32'hFFFF_FFFF) SHALL NOT be issued; instruction SHALL become NOP_WORD (32'h0000_0000), instr_valid SHALL stay 0, and the state SHALL go to DRAIN.
REQ-013 halt_req=1 sampled in any RUN cycle SHALL let the current slot complete, discard any prefetched word, present NOP_WORD from the next slot boundary, and enter DRAIN; pc SHALL hold.
REQ-014 After the slot at pc=2^ADDR_W-1 completes, the block SHALL enter DRAIN rather than wrap; no read of address 0 SHALL be issued.
REQ-015 DRAIN SHALL present NOP_WORD for DRAIN_SLOTS*ISSUE_GAP cycles with instr_valid=0 and imem_rd_en=0, then enter DONE.
REQ-016 DONE SHALL hold done=1, busy=0, instruction=NOP_WORD and pc at its last value until start.
REQ-017 If halt_req and a HALT_WORD load occur on the same edge, the block SHALL enter DRAIN once, with a single drain period.
REQ-018 imem_rd_en SHALL never be asserted outside PRIME entry and RUN prefetch.

Reset
REQ-019 rst=0 SHALL immediately force IDLE, cnt=0, instruction=NOP_WORD, instr_valid=0, imem_rd_en=0, imem_addr=0, pc=0, busy=0 and done=0, regardless of state.
REQ-020 Reset released mid-program SHALL NOT resume execution; a new start is required.

Structure
REQ-021 NOP_WORD, HALT_WORD and the state enumeration SHALL live in shared package cpu_pkg.
REQ-022 The slot counter SHALL be a sub-module issue_timer (inputs: enable, clear; outputs: cnt, prefetch strobe at ISSUE_GAP-2, slot_end at ISSUE_GAP-1).
REQ-023 Total RTL SHALL be 120-400 lines, with no latches and no combinational path from imem_rdata to outputs.

Verification
REQ-024 SHALL cover each directed scenario below, with a one-cycle synchronous-read model for imem:
- Memory [0]=A, [1]=B, [2]=HALT, start at t0: A is valid at t0+2, B at t0+5, then 9 NOP cycles, then done=1 at t0+17 (ISSUE_GAP=3).
- halt_req raised in the 2nd cycle of the B slot: B finishes, the prefetched C is never issued, pc stays 1, and drain follows.
- ADDR_W=2 with no HALT: four instructions are issued, pc ends at 3, and imem_addr never returns to 0.
- rst pulled low mid-RUN: all outputs reach reset values in the same cycle; start after release begins again at address 0.
- start pulsed in RUN and in DRAIN is ignored; start in DONE restarts cleanly, with done cleared in the start cycle.
- ISSUE_GAP=2: instr_valid pulses are exactly 2 cycles apart, and the prefetch occurs in the cnt=0 cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the instruction fetch block.
package cpu_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Slot counter width; covers the full ISSUE_GAP range of 2..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StRun,
        StDrain,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/issue_timer.sv
// Slot counter: counts 0..ISSUE_GAP-1 while enabled and flags the prefetch
// and slot-end cycles of each instruction slot.
module issue_timer
    import cpu_pkg::*;
#(
    parameter int unsigned ISSUE_GAP = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             prefetch_o,
    output logic             slot_end_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ISSUE_GAP - 1);
    localparam logic [CNT_W-1:0] PrefCnt = CNT_W'(ISSUE_GAP - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at the last slot cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign prefetch_o = enable_i && !clear_i && (cnt_q == PrefCnt);
    assign slot_end_o = enable_i && !clear_i && (cnt_q == LastCnt);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: streams words from a synchronous-read
// instruction memory to the core, one word per ISSUE_GAP-cycle slot, then
// flushes the pipeline with NOP slots before reporting done.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned ISSUE_GAP   = 3,
    parameter int unsigned DRAIN_SLOTS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       DRAIN_W   = (DRAIN_SLOTS > 1) ? $clog2(DRAIN_SLOTS) : 1;
    localparam logic [DRAIN_W-1:0] DrainLast = DRAIN_W'(DRAIN_SLOTS - 1);
    localparam logic [ADDR_W-1:0]  PcMax     = '1;

    fetch_state_e        state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                halt_pend_q, halt_pend_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    logic [CNT_W-1:0]    cnt;
    logic                timer_en;
    logic                prefetch;
    logic                slot_end;
    logic                accept;
    logic                last_pc;
    logic                fetch_next;

    assign timer_en   = (state_q == StRun) || (state_q == StDrain);
    assign last_pc    = (pc_q == PcMax);
    // Gated by rst so a start held during reset cannot leak a read request.
    assign accept     = rst && start && ((state_q == StIdle) || (state_q == StDone));
    // No prefetch past the top address: the program ends instead of wrapping.
    assign fetch_next = (state_q == StRun) && prefetch && !last_pc;

    issue_timer #(
        .ISSUE_GAP (ISSUE_GAP)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .enable_i   (timer_en),
        .clear_i    (!timer_en),
        .cnt_o      (cnt),
        .prefetch_o (prefetch),
        .slot_end_o (slot_end)
    );

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        halt_pend_d = halt_pend_q;
        drain_d     = drain_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d     = StPrime;
                    halt_pend_d = 1'b0;
                    drain_d     = '0;
                end
            end
            StPrime: begin
                pc_d = '0;
                if (imem_rdata == HALT_WORD) begin
                    instr_d = NOP_WORD;
                    state_d = StDrain;
                end else begin
                    instr_d = imem_rdata;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (slot_end) begin
                    if (halt_pend_q || halt_req || last_pc) begin
                        // Prefetched word (if any) is dropped; pc stays on the last issued slot.
                        instr_d     = NOP_WORD;
                        halt_pend_d = 1'b0;
                        state_d     = StDrain;
                    end else if (imem_rdata == HALT_WORD) begin
                        instr_d = NOP_WORD;
                        state_d = StDrain;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (slot_end) begin
                    if (drain_q == DrainLast) begin
                        state_d = StDone;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            instr_q     <= NOP_WORD;
            pc_q        <= '0;
            halt_pend_q <= 1'b0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            halt_pend_q <= halt_pend_d;
            drain_q     <= drain_d;
        end
    end

    // Outputs: all registered except the start-cycle handshake.
    always_comb begin
        imem_rd_en  = accept || fetch_next;
        imem_addr   = fetch_next ? pc_q + 1'b1 : '0;
        instr_valid = (state_q == StRun) && (cnt == '0);
        busy        = accept || (state_q == StPrime) || (state_q == StRun) ||
                      (state_q == StDrain);
        done        = (state_q == StDone) && !accept;
        instruction = instr_q;
        pc          = pc_q;
    end

endmodule
